drain_channel_rr: RTL and testbench

- Parametrised drain-network node shared by NUM_PE processing elements. Each node sits in the vertical drain chain of the systolic array.
- Each cycle it arbitrates round-robin among the local PEs and the chained node below, and pushes at most one word into a local FIFO.
- The FIFO drives the node above through a valid/ready handshake.
- Unlike the previous fixed two-PE, unbuffered pipe stage, this block adds fair arbitration, buffering and backpressure, so no result is ever lost when the chain stalls.

---
 rtl/drain_channel_rr.sv | 109 ++++++++++
 tb/tb_drain_channel_rr.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drain_channel_rr.sv
// Drain-chain node: round-robin arbitration between local PEs and the node below,
// feeding a small circular FIFO that drives the node above over valid/ready.
module drain_channel_rr #(
    parameter int NUM_PE     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PE-1:0]                pe_valid_i,
    input  logic [NUM_PE*DATA_W-1:0]         pe_data_i,
    output logic [NUM_PE-1:0]                pe_ready_o,
    input  logic                             down_valid_i,
    input  logic [DATA_W-1:0]                down_data_i,
    output logic                             down_ready_o,
    output logic                             up_valid_o,
    output logic [DATA_W-1:0]                up_data_o,
    input  logic                             up_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);

    localparam int unsigned NR = NUM_PE + 1;
    localparam int unsigned PW = $clog2(NR);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [PW-1:0]     r_ptr;
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    logic [NR-1:0]     w_req;
    logic [NR-1:0]     w_ready;
    logic              w_gnt_vld;
    logic [PW-1:0]     w_gnt;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_pop;
    logic              w_can_push;
    logic              w_push;

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Requester NUM_PE (the top bit) is the chained node below.
    assign w_req = {down_valid_i, pe_valid_i};

    always_comb begin : arb
        int unsigned idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= NR) idx = idx - NR;
            if (!w_gnt_vld && w_req[idx[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = idx[PW-1:0];
            end
        end
    end

    always_comb begin : gnt_mux
        w_gnt_data = down_data_i;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            if (32'(w_gnt) == k) w_gnt_data = pe_data_i[k*DATA_W +: DATA_W];
        end
    end

    assign w_pop      = up_valid_o && up_ready_i;
    assign w_can_push = (r_count < CW'(FIFO_DEPTH)) || w_pop;
    // Gating with rst_i keeps every ready low while reset is held.
    assign w_push     = rst_i && w_gnt_vld && w_can_push;

    always_comb begin : ready_dec
        w_ready = '0;
        if (w_push) w_ready[w_gnt] = 1'b1;
    end

    assign pe_ready_o   = w_ready[NUM_PE-1:0];
    assign down_ready_o = w_ready[NUM_PE];
    assign up_valid_o   = (r_count != '0);
    assign up_data_o    = r_mem[r_rd];
    assign count_o      = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ptr   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) r_mem[e] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_gnt_data;
                r_wr        <= f_next(r_wr);
                r_ptr       <= (32'(w_gnt) == NUM_PE) ? '0 : w_gnt + PW'(1);
            end
            if (w_pop) r_rd <= f_next(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_drain_channel_rr.sv
// Randomised and directed bench for drain_channel_rr: a queue-based reference model
// predicts grants, occupancy and word order; a separate monitor checks every popped word.
module tb_drain_channel_rr;

    localparam int NUM_PE = 2;
    localparam int DW     = 32;
    localparam int DEPTH  = 3;
    localparam int NR     = NUM_PE + 1;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SMAX   = 4096;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic [NUM_PE-1:0]    pe_valid_i = '0;
    logic [NUM_PE*DW-1:0] pe_data_i = '0;
    logic [NUM_PE-1:0]    pe_ready_o;
    logic                 down_valid_i = 1'b0;
    logic [DW-1:0]        down_data_i = '0;
    logic                 down_ready_o;
    logic                 up_valid_o;
    logic [DW-1:0]        up_data_o;
    logic                 up_ready_i = 1'b0;
    logic [CW-1:0]        count_o;

    always #5 clk = ~clk;

    drain_channel_rr #(
        .NUM_PE     (NUM_PE),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pe_valid_i   (pe_valid_i),
        .pe_data_i    (pe_data_i),
        .pe_ready_o   (pe_ready_o),
        .down_valid_i (down_valid_i),
        .down_data_i  (down_data_i),
        .down_ready_o (down_ready_o),
        .up_valid_o   (up_valid_o),
        .up_data_o    (up_data_o),
        .up_ready_i   (up_ready_i),
        .count_o      (count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-requester word sources; index NUM_PE is the node below.
    logic [DW-1:0] src_mem [NR][SMAX];
    int            src_wr [NR];
    int            src_rd [NR];
    bit            presented [NR];
    logic [NR-1:0] acc = '0;
    int            up_mode = 0;
    int            gap_pct = 0;

    // Reference model state: expected FIFO contents as a plain queue.
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            m_fresh = 1'b1;
    bit            m_in_rst = 1'b0;
    logic [DW-1:0] exp_q [$];

    always @(negedge clk) begin : model
        logic [NR-1:0] req;
        logic [NR-1:0] got;
        logic [NR-1:0] want;
        int            g;
        int            r;
        bit            pop_m;
        bit            room;
        req = {down_valid_i, pe_valid_i};
        got = {down_ready_o, pe_ready_o};
        acc = got & req;
        if (!rst_i) begin
            check("ready_in_reset", got, '0);
            if (m_in_rst) begin
                check("count_in_reset", count_o, 0);
                check("up_valid_in_reset", up_valid_o, 0);
                check("up_data_in_reset", up_data_o, 0);
            end
            m_ptr = 0;
            m_cnt = 0;
            exp_q.delete();
            m_fresh  = 1'b1;
            m_in_rst = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            check("count", count_o, m_cnt);
            check("up_valid", up_valid_o, (m_cnt != 0));
            if (m_fresh && m_cnt == 0) check("up_data_after_reset", up_data_o, 0);
            pop_m = (m_cnt > 0) && up_ready_i;
            room  = (m_cnt < DEPTH) || pop_m;
            g = -1;
            for (int i = 0; i < NR; i++) begin
                r = (m_ptr + i) % NR;
                if (g < 0 && req[r]) g = r;
            end
            want = '0;
            if (g >= 0 && room) want[g] = 1'b1;
            check("ready", got, want);
            if (want != '0) begin
                exp_q.push_back((g == NUM_PE) ? down_data_i : pe_data_i[g*DW +: DW]);
                m_ptr   = (g == NUM_PE) ? 0 : g + 1;
                m_fresh = 1'b0;
                m_cnt++;
            end
            if (pop_m) m_cnt--;
        end
    end

    always @(negedge clk) begin : monitor
        if (rst_i && up_valid_o && up_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL up_data: got unexpected word %0h, expected none at %0t", up_data_o, $time);
            end else begin
                check("up_data", up_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic load(input int r, input logic [DW-1:0] w);
        if (src_wr[r] < SMAX) begin
            src_mem[r][src_wr[r]] = w;
            src_wr[r]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (presented[r] && acc[r]) begin
                src_rd[r]++;
                presented[r] = 1'b0;
            end
            if (!presented[r] && src_rd[r] < src_wr[r] && $urandom_range(99) >= gap_pct)
                presented[r] = 1'b1;
        end
        for (int r = 0; r < NUM_PE; r++) begin
            pe_valid_i[r] = presented[r];
            if (presented[r]) pe_data_i[r*DW +: DW] = src_mem[r][src_rd[r]];
        end
        down_valid_i = presented[NUM_PE];
        if (presented[NUM_PE]) down_data_i = src_mem[NUM_PE][src_rd[NUM_PE]];
        case (up_mode)
            0:       up_ready_i = 1'b1;
            1:       up_ready_i = 1'b0;
            2:       up_ready_i = ~up_ready_i;
            default: up_ready_i = ($urandom_range(1) == 1);
        endcase
    endtask

    function automatic bit busy();
        bit b;
        b = (m_cnt != 0);
        for (int r = 0; r < NR; r++) if (src_rd[r] < src_wr[r] || presented[r]) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int budget, input int mode);
        int n;
        up_mode = mode;
        gap_pct = 0;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        if (busy()) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words still pending, expected 0 within %0d cycles", m_cnt, budget);
        end
        step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int r = 0; r < NR; r++) begin
            src_wr[r] = 0;
            src_rd[r] = 0;
            presented[r] = 1'b0;
        end
        // Reset with all requesters valid, then round-robin streaming.
        for (int k = 0; k < 4; k++) begin
            load(0, 32'h10);
            load(1, 32'h11);
            load(2, 32'h20);
        end
        rst_i = 1'b0;
        step(); step(); step();
        rst_i = 1'b1;
        drain(100, 0);

        load(0, 32'hA5);
        drain(20, 0);

        // Backpressure: one more word than the FIFO holds.
        up_mode = 1;
        for (int k = 1; k <= DEPTH + 1; k++) load(0, k);
        for (int k = 0; k < 6; k++) step();
        drain(40, 0);

        // Non-power-of-2 wrap with toggling up_ready.
        for (int k = 1; k <= 9; k++) load(2, k);
        drain(100, 2);

        // Reset with words buffered, then a fresh word from PE1.
        up_mode = 1;
        load(0, 32'h31); load(0, 32'h32); load(0, 32'h33);
        for (int k = 0; k < 5; k++) step();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        load(1, 32'h77);
        drain(40, 0);

        // Random traffic with occasional resets.
        up_mode = 3;
        gap_pct = 30;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 45) load($urandom_range(NR - 1), $urandom);
            rst_i = ($urandom_range(199) != 0);
            step();
        end
        rst_i = 1'b1;
        drain(2000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
